// File: rtl/inventory_bank.sv
// inventory_bank: per-slot saturating-width inventory with charge/dispense/clear/query over valid/ready.
// Define INV_SATURATE_EN to clamp charge overflow to full scale as a warning instead of rejecting it.
module inventory_bank #(
    parameter int NUM_SLOTS = 5,
    parameter int CNT_W = 4,
    parameter int IDX_W = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_mode,
    input  logic [IDX_W-1:0]           req_index,
    input  logic [CNT_W-1:0]           req_amount,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_error,
    output logic [1:0]                 rsp_code,
    output logic [CNT_W-1:0]           rsp_count,
    output logic [NUM_SLOTS*CNT_W-1:0] all_num,
    output logic [NUM_SLOTS-1:0]       empty_mask,
    output logic [7:0]                 err_count
);
`ifdef INV_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic [1:0] M_QRY = 2'b00, M_CHG = 2'b01, M_DSP = 2'b10;
    localparam logic [1:0] C_OK = 2'b00, C_BAD = 2'b01, C_OVF = 2'b10, C_UNF = 2'b11;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t                     state;
    logic [1:0]                 mode_q;
    logic [IDX_W-1:0]           idx_q;
    logic [CNT_W-1:0]           amt_q;
    logic [CNT_W-1:0]           cur, new_cnt;
    logic [CNT_W:0]             sum;
    logic                       idx_ok, ovf, unf, err, wr;
    logic [1:0]                 code;
    logic [NUM_SLOTS*CNT_W-1:0] next_all;
    logic [NUM_SLOTS-1:0]       next_empty;
    // The store is all_num itself; EXEC computes the whole next image of it.
    always_comb begin
        cur = '0;
        for (int k = 0; k < NUM_SLOTS; k++)
            if (idx_q == IDX_W'(k + 1)) cur = all_num[k*CNT_W +: CNT_W];
        idx_ok = (idx_q != '0) && (idx_q <= IDX_W'(NUM_SLOTS));
        sum = {1'b0, cur} + {1'b0, amt_q};
        ovf = sum[CNT_W];
        unf = amt_q > cur;
        code = !idx_ok ? C_BAD : (mode_q == M_CHG && ovf) ? C_OVF : (mode_q == M_DSP && unf) ? C_UNF : C_OK;
        err = !idx_ok || (mode_q == M_CHG && ovf && !SAT) || (mode_q == M_DSP && unf);
        new_cnt = mode_q == M_QRY ? cur :
                  mode_q == M_CHG ? (ovf ? (SAT ? {CNT_W{1'b1}} : cur) : sum[CNT_W-1:0]) :
                  mode_q == M_DSP ? (unf ? cur : cur - amt_q) : '0;
        wr = idx_ok && !err && mode_q != M_QRY;
        next_all = all_num;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (wr && idx_q == IDX_W'(k + 1)) next_all[k*CNT_W +: CNT_W] = new_cnt;
            next_empty[k] = next_all[k*CNT_W +: CNT_W] == '0;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            all_num <= '0;
            empty_mask <= '1;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_code <= C_OK;
            rsp_count <= '0;
            err_count <= '0;
            mode_q <= '0;
            idx_q <= '0;
            amt_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        state <= EXEC;
                        req_ready <= 1'b0;
                        mode_q <= req_mode;
                        idx_q <= req_index;
                        amt_q <= req_amount;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                EXEC: begin
                    state <= RESP;
                    all_num <= next_all;
                    empty_mask <= next_empty;
                    rsp_valid <= 1'b1;
                    rsp_error <= err;
                    rsp_code <= code;
                    rsp_count <= idx_ok ? new_cnt : '0;
                    if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
